// File: rtl/sid_link_pkg.sv
// Shared definitions for the SID register-write serial link:
// write-request struct, pair FSM states and frame timing helpers.
package sid_link_pkg;

  localparam logic [4:0] SID_ADDR_MAX    = 5'h1F;
  localparam int         UART_OVERSAMPLE = 8;

  typedef struct packed {
    logic [4:0] addr;
    logic [7:0] data;
  } sid_wr_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND_ADDR = 2'd1,
    SEND_DATA = 2'd2
  } sid_tx_state_e;

  // Address byte as the SID receiver expects it: upper three bits always zero.
  function automatic logic [7:0] addr_byte(input logic [4:0] addr);
    return {3'b000, addr & SID_ADDR_MAX};
  endfunction

  // Bit-period down-counter reload value; a prescale of 0 behaves as 1.
  function automatic logic [18:0] bit_reload(input logic [15:0] prescale);
    logic [18:0] ps;
    ps = (prescale == 16'd0) ? 19'd1 : {3'b000, prescale};
    return (ps * 19'(UART_OVERSAMPLE)) - 19'd1;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// One 8N1 frame serializer. A start request is taken while idle or in the
// final cycle of the stop bit, so consecutive frames can run with no gap.
// prescale is captured when a frame is loaded and held for that frame.
module uart_tx_byte
  import sid_link_pkg::*;
(
  input  logic        clk,
  input  logic        n_reset,
  input  logic [15:0] prescale,
  input  logic        start,
  input  logic [7:0]  byte_data,
  output logic        txd,
  output logic        done
);

  logic        active;
  logic [3:0]  bit_idx;
  logic [18:0] timer;
  logic [18:0] reload_q;
  logic [7:0]  shreg;
  logic        load;

  // done marks the last clock of the stop bit
  assign done = active && (bit_idx == 4'd9) && (timer == 19'd0);
  assign load = start && (!active || done);

  // Frame sequencer: start bit, data LSB first, stop bit
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      active   <= 1'b0;
      bit_idx  <= 4'd0;
      timer    <= 19'd0;
      reload_q <= 19'd0;
      shreg    <= 8'h00;
      txd      <= 1'b1;
    end else if (load) begin
      active   <= 1'b1;
      bit_idx  <= 4'd0;
      timer    <= bit_reload(prescale);
      reload_q <= bit_reload(prescale);
      shreg    <= byte_data;
      txd      <= 1'b0;
    end else if (active) begin
      if (timer != 19'd0) begin
        timer <= timer - 19'd1;
      end else if (bit_idx == 4'd9) begin
        active <= 1'b0;
        txd    <= 1'b1;
      end else begin
        bit_idx <= bit_idx + 4'd1;
        timer   <= reload_q;
        if (bit_idx == 4'd8) begin
          txd <= 1'b1;
        end else begin
          txd   <= shreg[0];
          shreg <= {1'b0, shreg[7:1]};
        end
      end
    end
  end

endmodule

// File: rtl/sid_reg_tx.sv
// SID register-write transmitter: each accepted (addr, data) request goes
// out as an address frame followed immediately by its data frame.
// Build option SID_TX_FIFO_EN: a FIFO_DEPTH-entry request FIFO replaces the
// single holding register, so wr_ready stays up while a pair is on the line.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | line idle (txd high), waiting for a buffered request
// SEND_ADDR | address frame {3'b000, addr} on the line
// SEND_DATA | data frame on the line; next pair may chain at its end
module sid_reg_tx
  import sid_link_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [15:0] prescale,
  input  logic        wr_valid,
  input  logic [4:0]  wr_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_ready,
  output logic        txd,
  output logic        busy
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
    $error("sid_reg_tx: FIFO_DEPTH must be a power of two and at least 2");
  end

  sid_tx_state_e state;
  logic [7:0]    data_q;
  logic          rst_done;
  sid_wr_t       head;
  logic          avail;
  logic          push;
  logic          pop;
  logic          tx_start;
  logic [7:0]    tx_byte;
  logic          tx_done;

  assign push = wr_valid && wr_ready;

  // A buffered pair is taken when the line is idle or right as a data frame ends
  assign pop      = avail && ((state == IDLE) || ((state == SEND_DATA) && tx_done));
  assign tx_start = pop || ((state == SEND_ADDR) && tx_done);
  assign tx_byte  = (state == SEND_ADDR) ? data_q : addr_byte(head.addr);
  assign busy     = (state != IDLE) || avail;

  // Keeps wr_ready low while reset is held and until the first clock after it
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) rst_done <= 1'b0;
    else          rst_done <= 1'b1;
  end

`ifdef SID_TX_FIFO_EN
  localparam int         AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  sid_wr_t       mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  // Occupancy is registered, so a full FIFO refuses a write even if it pops
  assign wr_ready = rst_done && (count != DEPTH_C);
  assign avail    = (count != '0);
  assign head     = mem[rd_ptr];

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sid_wr_t'{addr: wr_addr, data: wr_data};
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW + 1)'(1);
      else if (pop && !push) count <= count - (AW + 1)'(1);
    end
  end
`else
  sid_wr_t hold_q;
  logic    hold_valid;

  assign wr_ready = rst_done && (state == IDLE) && !hold_valid;
  assign avail    = hold_valid;
  assign head     = hold_q;

  // Single-entry holding register between the handshake and the FSM
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      hold_q     <= '0;
      hold_valid <= 1'b0;
    end else if (push) begin
      hold_q     <= sid_wr_t'{addr: wr_addr, data: wr_data};
      hold_valid <= 1'b1;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end
`endif

  // Pair FSM: address frame, then data frame, optionally chaining the next pair
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state  <= IDLE;
      data_q <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            data_q <= head.data;
            state  <= SEND_ADDR;
          end
        end
        SEND_ADDR: begin
          if (tx_done) state <= SEND_DATA;
        end
        SEND_DATA: begin
          if (tx_done) begin
            if (pop) begin
              data_q <= head.data;
              state  <= SEND_ADDR;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  uart_tx_byte u_uart_tx_byte (
    .clk       (clk),
    .n_reset   (n_reset),
    .prescale  (prescale),
    .start     (tx_start),
    .byte_data (tx_byte),
    .txd       (txd),
    .done      (tx_done)
  );

endmodule

// File: tb/tb_sid_reg_tx.sv
// Bench for sid_reg_tx: a line-level model (queues of pending pairs, bytes
// and per-cycle line levels) checked against the DUT every cycle, plus
// hand-computed waveforms and timings for the key scenarios.
module tb_sid_reg_tx;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic [15:0] prescale = 16'd1;
  logic        wr_valid = 1'b0;
  logic [4:0]  wr_addr = 5'd0;
  logic [7:0]  wr_data = 8'd0;
  logic        wr_ready;
  logic        txd;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  sid_reg_tx #(.FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .n_reset  (n_reset),
    .prescale (prescale),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .txd      (txd),
    .busy     (busy)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- line model ----------------
  typedef struct {
    logic [4:0] a;
    logic [7:0] d;
  } pair_t;

  pair_t      pend_q[$];
  logic [7:0] byte_q[$];
  logic       cyc_q[$];
  logic       m_txd = 1'b1;
  logic       m_busy = 1'b0;
  logic       m_ready = 1'b0;
  logic       m_in_frame = 1'b0;

  function automatic void expand(input logic [7:0] b, input logic [15:0] ps);
    int len;
    len = ((ps == 16'd0) ? 1 : int'(ps)) * 8;
    for (int i = 0; i < len; i++) cyc_q.push_back(1'b0);
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < len; i++) cyc_q.push_back(b[k]);
    for (int i = 0; i < len; i++) cyc_q.push_back(1'b1);
  endfunction

  always @(posedge clk or negedge n_reset) begin
    pair_t p;
    logic  acc;
    if (!n_reset) begin
      pend_q.delete();
      byte_q.delete();
      cyc_q.delete();
      m_txd = 1'b1;
      m_busy = 1'b0;
      m_ready = 1'b0;
      m_in_frame = 1'b0;
    end else begin
      acc = wr_valid && m_ready;
      if (cyc_q.size() == 0) begin
        if (byte_q.size() == 0 && pend_q.size() != 0) begin
          p = pend_q.pop_front();
          byte_q.push_back({3'b000, p.a});
          byte_q.push_back(p.d);
        end
        if (byte_q.size() != 0) expand(byte_q.pop_front(), prescale);
      end
      if (cyc_q.size() != 0) begin
        m_txd = cyc_q.pop_front();
        m_in_frame = 1'b1;
      end else begin
        m_txd = 1'b1;
        m_in_frame = 1'b0;
      end
      if (acc) begin
        p.a = wr_addr;
        p.d = wr_data;
        pend_q.push_back(p);
      end
`ifdef SID_TX_FIFO_EN
      m_ready = (pend_q.size() < DEPTH);
`else
      m_ready = !m_in_frame && byte_q.size() == 0 && pend_q.size() == 0;
`endif
      m_busy = m_in_frame || byte_q.size() != 0 || pend_q.size() != 0;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("txd_vs_model", txd, m_txd);
    chk("busy_vs_model", busy, m_busy);
    chk("wr_ready_vs_model", wr_ready, m_ready);
  end

  // ---------------- stimulus helpers ----------------
  // Holds wr_valid with junk addr/data until wr_ready, then presents the real beat
  task automatic do_write(input logic [4:0] a, input logic [7:0] d, output time t_acc);
    int  n;
    bit  fin;
    n = 0;
    fin = 0;
    t_acc = 0;
    @(negedge clk);
    while (!fin) begin
      wr_valid = 1'b1;
      if (wr_ready) begin
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        t_acc = $time;
        #1 wr_valid = 1'b0;
        fin = 1;
      end else begin
        wr_addr = 5'($urandom);
        wr_data = 8'($urandom);
        n++;
        if (n > 20000) begin
          chk("write_accept_timeout", 0, 1);
          wr_valid = 1'b0;
          fin = 1;
        end else begin
          @(negedge clk);
        end
      end
    end
  endtask

  // Called right after the accepting edge; checks mid-bit levels of both frames
  task automatic check_frames(input logic [19:0] exp, input int bitlen, input string nm);
    bit busy_ok;
    busy_ok = 1;
    for (int j = 0; j <= 20 * bitlen; j++) begin
      @(negedge clk);
      if (!busy) busy_ok = 0;
      if (j >= 1 && ((j - 1) % bitlen) == bitlen / 2)
        chk(nm, txd, exp[(j - 1) / bitlen]);
    end
    chk({nm, "_busy_held"}, busy_ok, 1);
    @(negedge clk);
    chk({nm, "_end_busy"}, busy, 0);
    chk({nm, "_end_txd"}, txd, 1);
    chk({nm, "_end_ready"}, wr_ready, 1);
  endtask

  // Negedges from the accepting edge until busy drops; optionally changes prescale
  task automatic measure_busy(input int set_at, input logic [15:0] new_ps, output int len);
    len = -1;
    for (int j = 0; j < 20000; j++) begin
      @(negedge clk);
      if (j == set_at) prescale = new_ps;
      if (!busy) begin
        len = j;
        break;
      end
    end
  endtask

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 0;
    for (int j = 0; j < 20000; j++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    chk(nm, ok, 1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] lit_18_0f;
    time         t0, t1;
    time         tk[6];
    int          len;

    // 0x18 frame bits 0..9 then 0x0F frame bits 10..19 (index 0 = first on line)
    lit_18_0f = 20'b1000011110_1000110000;

    #23;
    chk("reset_txd", txd, 1);
    chk("reset_busy", busy, 0);
    chk("reset_ready", wr_ready, 0);
    @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", wr_ready, 1);

    // single pair at prescale 1
    prescale = 16'd1;
    do_write(5'h18, 8'h0F, t0);
    check_frames(lit_18_0f, 8, "pair_18_0f_p1");

    // two consecutive writes
    do_write(5'h04, 8'h11, t0);
    do_write(5'h05, 8'h22, t1);
`ifdef SID_TX_FIFO_EN
    chk("second_accept_gap", 32'(t1 - t0), 32'd10);
`else
    chk("second_accept_gap", 32'(t1 - t0), 32'd1620);
`endif
    wait_idle("idle_after_two");

    // prescale change mid address frame: 80 cycles at 8/bit + 160 at 16/bit
    do_write(5'h18, 8'h0F, t0);
    measure_busy(20, 16'd2, len);
    chk("ps_change_pair_len", 32'(len), 32'd241);
    prescale = 16'd1;

    // prescale 0 behaves as 1
    prescale = 16'd0;
    do_write(5'h1F, 8'hFF, t0);
    measure_busy(-1, 16'd0, len);
    chk("ps_zero_pair_len", 32'(len), 32'd161);
    prescale = 16'd1;

    // reset during data bit 3 (0x07 bit 3 is 0, frame position 14)
    do_write(5'h18, 8'h07, t0);
    for (int j = 0; j <= 116; j++) @(negedge clk);
    chk("pre_reset_txd_low", txd, 0);
    #1 n_reset = 1'b0;
    #1;
    chk("midframe_reset_txd", txd, 1);
    chk("midframe_reset_busy", busy, 0);
    chk("midframe_reset_ready", wr_ready, 0);
    @(negedge clk);
    n_reset = 1'b1;
    do_write(5'h18, 8'h0F, t0);
    check_frames(lit_18_0f, 8, "pair_after_reset");

`ifdef SID_TX_FIFO_EN
    // six writes every cycle: five taken back to back, sixth after first pair ends
    for (int k = 0; k < 6; k++) begin
      do_write(5'(5'h0A + k), 8'(8'hA0 + k), t1);
      tk[k] = t1;
    end
    for (int k = 1; k < 5; k++) chk("fifo_burst_gap", 32'(tk[k] - tk[0]), 32'(10 * k));
    chk("fifo_sixth_gap", 32'(tk[5] - tk[0]), 32'd1620);
    wait_idle("idle_after_fifo_burst");
`else
    tk[0] = 0;
`endif

    // long bit period
    prescale = 16'd55;
    do_write(5'h18, 8'h0F, t0);
    check_frames(lit_18_0f, 440, "pair_18_0f_p55");
    prescale = 16'd1;

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
